// File: rtl/mackerel_pkg.sv
// ============================================================================
// mackerel_pkg
// Shared state/cycle-class encodings and default timing constants for the
// Mackerel bus-cycle terminator and address decoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mackerel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACK   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE = 3'd0,
        CL_RAM  = 3'd1,
        CL_ROM  = 3'd2,
        CL_MFP  = 3'd3,
        CL_IACK = 3'd4
    } class_t;

    localparam int C_DEFAULT_ROM_WS       = 2;
    localparam int C_DEFAULT_RAM_WS       = 0;
    localparam int C_DEFAULT_BERR_TIMEOUT = 64;

    // MFPEN is not qualified by AS upstream, so it is gated here.
    function automatic class_t decode_class(
        input logic       as_n,
        input logic       romen_n,
        input logic [2:0] ramen_n,
        input logic       mfpen_n,
        input logic       iack_n
    );
        class_t cls;
        if (!iack_n)
            cls = CL_IACK;
        else if (!mfpen_n && !as_n)
            cls = CL_MFP;
        else if (!romen_n)
            cls = CL_ROM;
        else if (!(&ramen_n))
            cls = CL_RAM;
        else
            cls = CL_NONE;
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mackerel_bus_watchdog.sv
// ============================================================================
// mackerel_bus_watchdog
// 8-bit bus-cycle counter with clear/enable; o_tc flags the edge on which
// the count reaches TIMEOUT.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mackerel_bus_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [7:0] C_TC = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (!RST)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 8'd1;
    end

    // Count was cleared at E0, so reaching TIMEOUT-1 means this edge is E0+TIMEOUT.
    assign o_tc = i_en && (r_cnt == C_TC);

endmodule

`default_nettype wire

// File: rtl/mackerel_bus_ctrl.sv
// ============================================================================
// mackerel_bus_ctrl
// 68k bus-cycle terminator: registered DTACK with per-region wait states,
// autovector VPA for unanswered IACK, watchdog BERR with saturating count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mackerel_bus_ctrl
    import mackerel_pkg::*;
#(
    parameter int ROM_WS       = C_DEFAULT_ROM_WS,
    parameter int RAM_WS       = C_DEFAULT_RAM_WS,
    parameter int BERR_TIMEOUT = C_DEFAULT_BERR_TIMEOUT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       AS,
    input  logic       ROMEN,
    input  logic [2:0] RAMEN,
    input  logic       MFPEN,
    input  logic       IACK,
    input  logic       DTACK_MFP,
    output logic       DTACK,
    output logic       VPA,
    output logic       BERR,
    output logic [7:0] BERR_CNT
);

    state_t     r_state,    w_state;
    class_t     r_class,    w_class;
    logic [3:0] r_ws_cnt,   w_ws_cnt;
    logic       r_dtack,    w_dtack;
    logic       r_vpa,      w_vpa;
    logic       r_berr,     w_berr;
    logic [7:0] r_berr_cnt, w_berr_cnt;

    logic   w_wd_clr;
    logic   w_wd_en;
    logic   w_wd_tc;
    logic   w_ack;
    class_t w_sel_class;

    assign w_sel_class = decode_class(AS, ROMEN, RAMEN, MFPEN, IACK);

    mackerel_bus_watchdog #(
        .TIMEOUT (BERR_TIMEOUT)
    ) u_watchdog (
        .CLK   (CLK),
        .RST   (RST),
        .i_clr (w_wd_clr),
        .i_en  (w_wd_en),
        .o_tc  (w_wd_tc)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_class    <= CL_NONE;
            r_ws_cnt   <= '0;
            r_dtack    <= 1'b1;
            r_vpa      <= 1'b1;
            r_berr     <= 1'b1;
            r_berr_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_class    <= w_class;
            r_ws_cnt   <= w_ws_cnt;
            r_dtack    <= w_dtack;
            r_vpa      <= w_vpa;
            r_berr     <= w_berr;
            r_berr_cnt <= w_berr_cnt;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_class    = r_class;
        w_ws_cnt   = r_ws_cnt;
        w_dtack    = r_dtack;
        w_vpa      = r_vpa;
        w_berr     = r_berr;
        w_berr_cnt = r_berr_cnt;
        w_wd_clr   = 1'b0;
        w_wd_en    = 1'b0;
        w_ack      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_dtack = 1'b1;
                w_vpa   = 1'b1;
                w_berr  = 1'b1;
                if (!AS) begin
                    w_state  = ST_WAIT;
                    w_class  = w_sel_class;
                    w_wd_clr = 1'b1;
                    case (w_sel_class)
                        CL_ROM:  w_ws_cnt = 4'(ROM_WS);
                        CL_RAM:  w_ws_cnt = 4'(RAM_WS);
                        default: w_ws_cnt = 4'd0;
                    endcase
                end
            end

            ST_WAIT: begin
                if (AS) begin
                    // Aborted cycle: nothing asserted, nothing counted.
                    w_state = ST_IDLE;
                end else begin
                    w_wd_en = 1'b1;
                    case (r_class)
                        CL_ROM, CL_RAM: begin
                            w_ack = (r_ws_cnt == 4'd0);
                            if (r_ws_cnt != 4'd0)
                                w_ws_cnt = r_ws_cnt - 4'd1;
                        end
                        CL_MFP, CL_IACK: w_ack = !DTACK_MFP;
                        default:         w_ack = 1'b0;
                    endcase

                    // A real acknowledge beats a coincident timeout.
                    if (w_ack) begin
                        w_dtack = 1'b0;
                        w_state = ST_ACK;
                    end else if (w_wd_tc) begin
                        if (r_class == CL_IACK) begin
                            w_vpa   = 1'b0;
                            w_state = ST_ACK;
                        end else begin
                            w_berr  = 1'b0;
                            w_state = ST_FAULT;
                            if (r_berr_cnt != 8'hFF)
                                w_berr_cnt = r_berr_cnt + 8'd1;
                        end
                    end
                end
            end

            ST_ACK, ST_FAULT: begin
                if (AS) begin
                    w_dtack = 1'b1;
                    w_vpa   = 1'b1;
                    w_berr  = 1'b1;
                    w_state = ST_IDLE;
                end
            end

            default: w_state = ST_IDLE;
        endcase
    end

    assign DTACK    = r_dtack;
    assign VPA      = r_vpa;
    assign BERR     = r_berr;
    assign BERR_CNT = r_berr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mackerel_bus_ctrl.sv
// ============================================================================
// tb_mackerel_bus_ctrl
// Directed and randomized bus cycles checked against a cycle-outcome model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mackerel_bus_ctrl;

    localparam int ROM_WS = 2;
    localparam int RAM_WS = 0;
    localparam int TO     = 64;

    logic       CLK = 1'b0;
    logic       RST;
    logic       AS;
    logic       ROMEN;
    logic [2:0] RAMEN;
    logic       MFPEN;
    logic       IACK;
    logic       DTACK_MFP;
    logic       DTACK;
    logic       VPA;
    logic       BERR;
    logic [7:0] BERR_CNT;

    int n_cmp     = 0;
    int n_err     = 0;
    int model_cnt = 0;

    mackerel_bus_ctrl #(
        .ROM_WS       (ROM_WS),
        .RAM_WS       (RAM_WS),
        .BERR_TIMEOUT (TO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .AS        (AS),
        .ROMEN     (ROMEN),
        .RAMEN     (RAMEN),
        .MFPEN     (MFPEN),
        .IACK      (IACK),
        .DTACK_MFP (DTACK_MFP),
        .DTACK     (DTACK),
        .VPA       (VPA),
        .BERR      (BERR),
        .BERR_CNT  (BERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic d, input logic v, input logic b);
        chk({tag, ".DTACK"}, {7'd0, DTACK}, {7'd0, d});
        chk({tag, ".VPA"},   {7'd0, VPA},   {7'd0, v});
        chk({tag, ".BERR"},  {7'd0, BERR},  {7'd0, b});
        chk({tag, ".CNT"},   BERR_CNT,      8'(model_cnt));
    endtask

    task automatic deselect;
        ROMEN     = 1'b1;
        RAMEN     = 3'b111;
        MFPEN     = 1'b1;
        IACK      = 1'b1;
        DTACK_MFP = 1'b1;
    endtask

    // 4=IACK 3=MFP 2=ROM 1=RAM 0=NONE
    function automatic int model_class(input logic romen, input logic [2:0] ramen,
                                       input logic mfpen, input logic iack);
        if (!iack)             return 4;
        if (!mfpen)            return 3;
        if (!romen)            return 2;
        if (ramen != 3'b111)   return 1;
        return 0;
    endfunction

    // Outcome of a cycle: edge offset from E0 and which strobe (0=DTACK 1=VPA 2=BERR).
    task automatic model_outcome(input int cls, input int mfp_at,
                                 output int end_off, output int kind);
        if (cls == 2) begin
            end_off = 1 + ROM_WS; kind = 0;
        end else if (cls == 1) begin
            end_off = 1 + RAM_WS; kind = 0;
        end else if ((cls == 3 || cls == 4) && mfp_at >= 1 && mfp_at <= TO) begin
            end_off = mfp_at; kind = 0;
        end else begin
            end_off = TO;
            kind    = (cls == 4) ? 1 : 2;
        end
    endtask

    task automatic run_cycle(input string tag, input logic romen, input logic [2:0] ramen,
                             input logic mfpen, input logic iack,
                             input int mfp_at, input int abort_at);
        int  cls, end_off, kind, last;
        bit  aborted;
        logic ed, ev, eb;
        cls = model_class(romen, ramen, mfpen, iack);
        model_outcome(cls, mfp_at, end_off, kind);
        aborted = (abort_at > 0) && (abort_at <= end_off);
        last    = aborted ? abort_at : end_off;

        AS = 1'b0; ROMEN = romen; RAMEN = ramen; MFPEN = mfpen; IACK = iack; DTACK_MFP = 1'b1;
        tick;
        chk_out({tag, ".e0"}, 1'b1, 1'b1, 1'b1);

        for (int k = 1; k <= last; k++) begin
            DTACK_MFP = (mfp_at > 0 && k >= mfp_at) ? 1'b0 : 1'b1;
            if (aborted && k == abort_at) begin
                AS = 1'b1;
                deselect();
            end
            tick;
            if (!aborted && k == end_off && kind == 2 && model_cnt < 255)
                model_cnt++;
            ed = !(!aborted && k >= end_off && kind == 0);
            ev = !(!aborted && k >= end_off && kind == 1);
            eb = !(!aborted && k >= end_off && kind == 2);
            chk_out({tag, ".wait"}, ed, ev, eb);
        end
        if (aborted) return;

        repeat (2) begin
            tick;
            chk_out({tag, ".hold"}, kind != 0, kind != 1, kind != 2);
        end
        AS = 1'b1;
        deselect();
        tick;
        chk_out({tag, ".release"}, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        int mfp_at, abort_at;
        logic romen, mfpen, iack;
        logic [2:0] ramen;

        // Reset held with an active ROM cycle request on the bus
        RST = 1'b0; AS = 1'b0; deselect(); ROMEN = 1'b0;
        repeat (3) begin
            tick;
            chk_out("reset", 1'b1, 1'b1, 1'b1);
        end
        AS = 1'b1; deselect();
        tick;
        RST = 1'b1;
        tick;
        chk_out("post_reset", 1'b1, 1'b1, 1'b1);

        run_cycle("ram0",     1'b1, 3'b110, 1'b1, 1'b1, 0, 0);
        run_cycle("ram2",     1'b1, 3'b011, 1'b1, 1'b1, 0, 0);
        run_cycle("rom",      1'b0, 3'b111, 1'b1, 1'b1, 0, 0);
        run_cycle("mfp",      1'b1, 3'b111, 1'b0, 1'b1, 5, 0);
        run_cycle("mfp_rom",  1'b0, 3'b111, 1'b0, 1'b1, 5, 0);
        run_cycle("iack_av",  1'b1, 3'b111, 1'b1, 1'b0, 0, 0);
        run_cycle("iack_tie", 1'b1, 3'b111, 1'b1, 1'b0, TO, 0);
        run_cycle("mfp_tie",  1'b1, 3'b111, 1'b0, 1'b1, TO, 0);
        run_cycle("mfp_late", 1'b1, 3'b111, 1'b0, 1'b1, TO + 1, 0);

        for (int i = 0; i < 260; i++)
            run_cycle("unmapped", 1'b1, 3'b111, 1'b1, 1'b1, 0, 0);
        chk("saturated", BERR_CNT, 8'd255);

        run_cycle("abort", 1'b1, 3'b111, 1'b1, 1'b1, 0, 10);
        tick;
        chk_out("abort_idle", 1'b1, 1'b1, 1'b1);

        // Reset while a fault is being held
        AS = 1'b0; deselect();
        tick;
        repeat (TO) tick;
        chk_out("fault_held", 1'b1, 1'b1, 1'b0);
        RST = 1'b0;
        tick;
        model_cnt = 0;
        chk_out("fault_reset", 1'b1, 1'b1, 1'b1);
        AS = 1'b1;
        RST = 1'b1;
        tick;
        chk_out("fault_reset_idle", 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            romen    = 1'($urandom_range(0, 1));
            ramen    = 3'($urandom_range(0, 7));
            mfpen    = 1'($urandom_range(0, 2) != 0);
            iack     = 1'($urandom_range(0, 3) != 0);
            mfp_at   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, TO + 4));
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
            run_cycle("rand", romen, ramen, mfpen, iack, mfp_at, abort_at);
            if ($urandom_range(0, 1) == 1) tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
